// File: rtl/mdio_controller.sv
// MDIO station-management controller: serialises a 32-bit frame on MDC/MDIO_OUT and captures read data.
// Define MDIO_PREAMBLE_EN to prepend 32 all-ones preamble periods to every frame.
module mdio_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        MDIO_DONE,
  output logic        BUSY
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MID  = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MDIO_PREAMBLE_EN
    S_PREAMBLE,
`endif
    S_SEND,
    S_READ,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q;
  logic [30:0]   sh_q;
  logic          rd_q;
  logic [15:0]   cap_q;
  logic          mdc_q, out_q, oe_q, data_rdy_q, done_q, busy_q;
  logic [15:0]   rd_data_q;
`ifdef MDIO_PREAMBLE_EN
  logic          first_q;
`endif

  logic div_mid, div_end, start_rd;

  assign div_mid  = (div_q == DIV_MID);
  assign div_end  = (div_q == DIV_LAST);
  assign div_d    = div_end ? '0 : div_q + DW'(1);
  assign start_rd = (T_DATA[29:28] == 2'b10);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rd_q       <= 1'b0;
      cap_q      <= '0;
      mdc_q      <= 1'b0;
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      data_rdy_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
      first_q    <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      data_rdy_q <= 1'b0;
      // MDC low for the first half of each bit period, high for the second
      if (state_q != S_IDLE && state_q != S_DONE) begin
        div_q <= div_d;
        if (div_mid) mdc_q <= 1'b1;
        if (div_end) mdc_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (MDC_START) begin
            busy_q <= 1'b1;
            div_q  <= '0;
            mdc_q  <= 1'b0;
            oe_q   <= 1'b1;
            sh_q   <= T_DATA[30:0];
            rd_q   <= start_rd;
`ifdef MDIO_PREAMBLE_EN
            state_q <= S_PREAMBLE;
            out_q   <= 1'b1;
            bit_q   <= 5'd31;
            first_q <= T_DATA[31];
`else
            state_q <= S_SEND;
            out_q   <= T_DATA[31];
            bit_q   <= start_rd ? 5'd13 : 5'd31;
`endif
          end
        end
`ifdef MDIO_PREAMBLE_EN
        S_PREAMBLE: begin
          if (div_end) begin
            if (bit_q == 5'd0) begin
              state_q <= S_SEND;
              out_q   <= first_q;
              bit_q   <= rd_q ? 5'd13 : 5'd31;
            end else begin
              bit_q <= bit_q - 5'd1;
            end
          end
        end
`endif
        S_SEND: begin
          if (div_end) begin
            if (bit_q == 5'd0) begin
              oe_q  <= 1'b0;
              out_q <= 1'b0;
              if (rd_q) begin
                state_q <= S_READ;
                bit_q   <= 5'd17;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              bit_q <= bit_q - 5'd1;
              out_q <= sh_q[30];
              sh_q  <= {sh_q[29:0], 1'b0};
            end
          end
        end
        S_READ: begin
          // counts 17,16 are turnaround; data occupies counts 15..0
          if (div_mid && bit_q < 5'd16) cap_q <= {cap_q[14:0], MDIO_IN};
          if (div_end) begin
            if (bit_q == 5'd0) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              data_rdy_q <= 1'b1;
              rd_data_q  <= cap_q;
            end else begin
              bit_q <= bit_q - 5'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MDC       = mdc_q;
  assign MDIO_OUT  = out_q;
  assign MDIO_OE   = oe_q;
  assign RD_DATA   = rd_data_q;
  assign DATA_RDY  = data_rdy_q;
  assign MDIO_DONE = done_q;
  assign BUSY      = busy_q;

endmodule
